// File: rtl/bit_count_pkg.sv
// Shared types and elaboration-time helpers for the streaming bit counter.
package bit_count_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } bc_state_t;

    // Ceiling log2 for sizing counters at elaboration; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_count_accumulator_popcount.sv
// Purpose: population count of one CHUNK-bit slice.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module popcount_chunk
    import bit_count_pkg::*;
#(
    parameter int CHUNK = 8,
    localparam int CNT_W = clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] in,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + CNT_W'(in[i]);
        end
    end

endmodule

// File: rtl/bit_count_accumulator.sv
// Purpose: per-frame set/clear bit total, CHUNK bits counted per cycle.
// Latency: last word accepted at t -> total valid in cycle t+WIDTH/CHUNK+1.
// Backpressure: in_ready low while counting or holding a total; total held until out_ready.
module bit_count_accumulator
    import bit_count_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CHUNK     = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    // WIDTH must be an integer multiple of CHUNK.
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
    localparam int CNT_W  = clog2(CHUNK + 1);
    localparam int SUM_W  = ACC_WIDTH + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    bc_state_t              state;
    logic [WIDTH-1:0]       word;
    logic                   word_last;
    logic [IDX_W-1:0]       idx;
    logic [ACC_WIDTH-1:0]   acc;
    logic                   ovf;

    logic [CHUNK-1:0]       chunk;
    logic [CNT_W-1:0]       chunk_cnt;
    logic [SUM_W-1:0]       sum;
    logic [ACC_WIDTH-1:0]   acc_nxt;
    logic                   ovf_nxt;

    always_comb begin
        chunk = CHUNK'(word >> (CHUNK * idx));
    end

    popcount_chunk #(
        .CHUNK (CHUNK)
    ) u_popcount (
        .in    (chunk),
        .count (chunk_cnt)
    );

    // One extra sum bit makes overflow visible as the carry-out.
    always_comb begin
        sum     = SUM_W'(acc) + SUM_W'(chunk_cnt);
        acc_nxt = sum[ACC_WIDTH-1:0];
        ovf_nxt = ovf;
        if (sum[ACC_WIDTH]) begin
            acc_nxt = '1;
            ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            word      <= '0;
            word_last <= 1'b0;
            idx       <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        word      <= in_mode ? ~in_data : in_data;
                        word_last <= in_last;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        state     <= COUNT;
                    end
                end
                COUNT: begin
                    acc <= acc_nxt;
                    ovf <= ovf_nxt;
                    idx <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        idx <= '0;
                        if (word_last) begin
                            // Outputs load from the final sum so they are valid on entry to DONE.
                            out_valid <= 1'b1;
                            out_count <= acc_nxt;
                            out_ovf   <= ovf_nxt;
                            state     <= DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        out_count <= '0;
                        out_ovf   <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    acc       <= '0;
                    ovf       <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_count_accumulator.sv
// Directed bench: a 16-bit and a 6-bit accumulator share one input stream.
module tb_bit_count_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_mode = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_ovf;
    logic [15:0] out_count;
    logic        in_ready6, out_valid6, out_ovf6;
    logic [5:0]  out_count6;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    bit_count_accumulator #(.WIDTH(32), .CHUNK(8), .ACC_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    bit_count_accumulator #(.WIDTH(32), .CHUNK(8), .ACC_WIDTH(6)) dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready6),
        .in_data(in_data), .in_last(in_last), .in_mode(in_mode),
        .out_valid(out_valid6), .out_ready(out_ready),
        .out_count(out_count6), .out_ovf(out_ovf6)
    );

    // Called on a negedge; returns on the negedge right after the accepting posedge.
    task automatic send_word(input logic [31:0] d, input logic m, input logic l);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_word_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'h0;
        in_last  = 1'b0;
        in_mode  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 16'd0 || out_ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_count=%0d out_ovf=%b required 1 0 0 0",
                     in_ready, out_valid, out_count, out_ovf);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ones();
        send_word(32'd1299704331, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL ones_latency c%0d: out_valid=%b in_ready=%b required 0 0", k, out_valid, in_ready);
            end
            @(negedge clk);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_count !== 16'd18 || out_ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL ones_total: out_valid=%b out_count=%0d out_ovf=%b required 1 18 0", out_valid, out_count, out_ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL ones_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_zeros();
        send_word(32'd1299704331, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_count !== 16'd14 || out_ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL zeros_mode_total: out_valid=%b out_count=%0d out_ovf=%b required 1 14 0", out_valid, out_count, out_ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        send_word(32'h0000_0000, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_count !== 16'd0 || out_ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL zero_word_total: out_valid=%b out_count=%0d out_ovf=%b required 1 0 0", out_valid, out_count, out_ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Three full words: 96 in the wide accumulator, saturated at 63 in the narrow one.
    task automatic test_multi_word();
        for (int w = 0; w < 3; w++) begin
            send_word(32'hFFFF_FFFF, 1'b0, (w == 2));
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fails++;
                    $display("FAIL multi_in_ready_count w%0d c%0d: in_ready=%b required 0", w, k, in_ready);
                end
                @(negedge clk);
            end
            if (w < 2) begin
                n_checks++;
                if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                    n_fails++;
                    $display("FAIL multi_mid_frame w%0d: in_ready=%b out_valid=%b required 1 0", w, in_ready, out_valid);
                end
            end
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_count !== 16'd96 || out_ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL multi_total: out_valid=%b out_count=%0d out_ovf=%b required 1 96 0", out_valid, out_count, out_ovf);
        end
        n_checks++;
        if (out_valid6 !== 1'b1 || out_count6 !== 6'd63 || out_ovf6 !== 1'b1) begin
            n_fails++;
            $display("FAIL sat_total: out_valid=%b out_count=%0d out_ovf=%b required 1 63 1", out_valid6, out_count6, out_ovf6);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        send_word(32'h0000_0003, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (out_valid6 !== 1'b1 || out_count6 !== 6'd2 || out_ovf6 !== 1'b0) begin
            n_fails++;
            $display("FAIL sat_next_frame: out_valid=%b out_count=%0d out_ovf=%b required 1 2 0", out_valid6, out_count6, out_ovf6);
        end
        n_checks++;
        if (out_count !== 16'd2 || out_ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL wide_next_frame: out_count=%0d out_ovf=%b required 2 0", out_count, out_ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // out_ready asserted early (ignored before DONE), then held low for 6 cycles in DONE.
    task automatic test_back_pressure();
        send_word(32'h0F0F_0F0F, 1'b0, 1'b1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_count !== 16'd16 || in_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL hold_stable c%0d: out_valid=%b out_count=%0d in_ready=%b required 1 16 0",
                         k, out_valid, out_count, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midframe();
        send_word(32'hFFFF_FFFF, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        send_word(32'hFFFF_FFFF, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 16'd0 || out_ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL midframe_reset: in_ready=%b out_valid=%b out_count=%0d out_ovf=%b required 1 0 0 0",
                     in_ready, out_valid, out_count, out_ovf);
        end
        send_word(32'h0000_000F, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_count !== 16'd4 || out_ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL post_reset_total: out_valid=%b out_count=%0d out_ovf=%b required 1 4 0", out_valid, out_count, out_ovf);
        end
        n_checks++;
        if (out_count6 !== 6'd4 || out_ovf6 !== 1'b0) begin
            n_fails++;
            $display("FAIL post_reset_narrow: out_count=%0d out_ovf=%b required 4 0", out_count6, out_ovf6);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ones();
        test_zeros();
        test_multi_word();
        test_back_pressure();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1);
    end

endmodule
